hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter DW, 16, datapath width in bits.
REQ-002 Parameter AW, 3, register-address width in bits.
REQ-003 Parameter DEPTH, 2, number of tracked in-flight producer stages (legal 1..4); stage 1 = youngest (ALU result), stage DEPTH = oldest.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 instr  in  16  ID-stage instruction: opcode[15:12], rs[11:9], rt[8:6], rd[5:3] (AW=3 layout; fields widen with AW).
REQ-007 instr_valid  in  1  instr holds a real instruction this cycle.
REQ-008 flush  in  1  branch taken; invalidate all tracked producers.
REQ-009 stage_res  in  DEPTH*DW  producer results; slice k-1 = stage k.
REQ-010 fwd_op1_sel, fwd_op2_sel  out  1 each  use fwd_op1 / fwd_op2 instead of register-file read.
REQ-011 fwd_op1, fwd_op2  out  DW each  forwarded operand data.
REQ-012 fwd_wdata_sel  out  1  use fwd_wdata as sw store data.
REQ-013 fwd_wdata  out  DW  forwarded store data; 0 when fwd_wdata_sel=0.
REQ-014 stall  out  1  hold PC and ID register this cycle.

Function
REQ-015 Decode: op 0 sources rs,rt, dest rd; op 1,3 source rt, dest rs; op 4 (lw) source rs, dest rt, load; op 5 (sw) sources rs (address), rt (data), no dest; op 6 (beq) sources rs,rt, no dest; all other ops: no sources, no dest.
REQ-016 Tracker: DEPTH entries {valid, dest, is_load}; on each edge without stall, entry1 <= decoded instr (valid = instr_valid and dest exists and dest != 0), entry k <= entry k-1.
REQ-017 Register 0 is never tracked and never forwarded.
REQ-018 Source match: a source matches entry k when entry k is valid and dest equals the source; the youngest matching entry (lowest k) wins.
REQ-019 Outputs registered, 1-cycle latency: on the edge, sel <= match found, data <= stage_res slice of the winning k sampled at that edge; no match gives sel=0, data=0.
REQ-020 op1 path uses rs; op2 path uses rt for ops 0,1,3,6 only; sw rt drives the fwd_wdata path, never op2.
REQ-021 instr_valid=0: all sel outputs 0 next cycle, bubble (valid=0) shifted into tracker.
REQ-022 flush: all tracker entries cleared on that edge, all sel outputs 0 next cycle; flush overrides stall and instr_valid.
REQ-023 FSM states IDLE, STALL (only with REQ-030 macro).
REQ-024 IDLE: stall is combinational, asserted when instr_valid, entry1.valid, entry1.is_load and a source of instr equals entry1.dest; then next state STALL, bubble shifted into tracker, forwarding outputs 0.
REQ-025 STALL: stall=0 for exactly one cycle; re-presented instr now matches the load at stage 2 and forwards from it; return to IDLE.
REQ-026 Back-to-back load-use pairs each stall exactly one cycle; no two consecutive stall cycles.

Reset
REQ-027 rst=1: all tracker entries invalid, FSM IDLE, all sel outputs 0, all data outputs 0, stall 0.
REQ-028 rst asserted mid-stall aborts the stall; first cycle after rst deassert behaves as IDLE with empty tracker.
REQ-029 Outputs are reset values on the first edge after rst deasserts, regardless of instr.

Configuration
REQ-030 Macro HAZARD_LOAD_USE_STALL_EN: defined -> FSM and stall per REQ-023..026; undefined -> no FSM, stall tied 0, is_load ignored, load dests forwarded like ALU dests.

Verification
REQ-031 Reset: rst=1 three cycles with instr=0x0000 -> all outputs 0, stall 0.
REQ-032 R-type chain: add r3 (rd=3), then add with rs=3, stage_res[1]=0x1234 -> fwd_op1_sel=1, fwd_op1=0x1234 next cycle.
REQ-033 Priority: dest r2 at stage 1 and stage 2, consumer rt=2, stage1=0xAAAA, stage2=0x5555 -> fwd_op2=0xAAAA.
REQ-034 Load-use (macro on): lw dest r4, then add rs=4 -> stall=1 one cycle, then fwd_op1 = stage 2 value 0xBEEF; macro off -> stall never 1.
REQ-035 sw data: addi dest r5, then sw rt=5, stage1=0x00FF -> fwd_wdata_sel=1, fwd_wdata=0x00FF, fwd_op2_sel=0.
REQ-036 r0/flush: producer dest r0 then consumer rs=0 -> no forward; flush between producer r6 and consumer rs=6 -> no forward.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight producer destinations, selects forwarded operands,
// and (with HAZARD_LOAD_USE_STALL_EN defined) inserts a one-cycle load-use stall.
module hazard_ctrl #(
    parameter  int DW    = 16,
    parameter  int AW    = 3,
    parameter  int DEPTH = 2,
    localparam int IW    = 4 + 4*AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IW-1:0]       instr,
    input  logic                instr_valid,
    input  logic                flush,
    input  logic [DEPTH*DW-1:0] stage_res,
    output logic                fwd_op1_sel,
    output logic                fwd_op2_sel,
    output logic [DW-1:0]       fwd_op1,
    output logic [DW-1:0]       fwd_op2,
    output logic                fwd_wdata_sel,
    output logic [DW-1:0]       fwd_wdata,
    output logic                stall
);

    // Handshake: instr is consumed on a rising edge only when instr_valid=1 and stall=0;
    // while stall=1 the ID stage must hold and re-present the same instr next cycle.

    logic [3:0]    opcode;
    logic [AW-1:0] rs, rt, rd;
    logic          unused_low_bits;

    assign opcode          = instr[IW-1 -: 4];
    assign rs              = instr[IW-5 -: AW];
    assign rt              = instr[IW-5-AW -: AW];
    assign rd              = instr[IW-5-2*AW -: AW];
    assign unused_low_bits = ^instr[AW-1:0];

    logic          use_rs;
    logic          use_rt_op2;
    logic          use_rt_wd;
    logic          has_dest;
    logic [AW-1:0] dest;

    always_comb begin
        use_rs     = 1'b0;
        use_rt_op2 = 1'b0;
        use_rt_wd  = 1'b0;
        has_dest   = 1'b0;
        dest       = '0;
        case (opcode)
            4'd0: begin
                use_rs     = 1'b1;
                use_rt_op2 = 1'b1;
                has_dest   = 1'b1;
                dest       = rd;
            end
            4'd1, 4'd3: begin
                use_rt_op2 = 1'b1;
                has_dest   = 1'b1;
                dest       = rs;
            end
            4'd4: begin
                use_rs   = 1'b1;
                has_dest = 1'b1;
                dest     = rt;
            end
            4'd5: begin
                use_rs    = 1'b1;
                use_rt_wd = 1'b1;
            end
            4'd6: begin
                use_rs     = 1'b1;
                use_rt_op2 = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Producer tracker: index 0 is stage 1 (youngest).
    logic [DEPTH-1:0] trk_valid;
    logic [AW-1:0]    trk_dest [DEPTH];

    // Returns {hit, data}; the lowest stage index that matches wins.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] src);
        logic [DW:0] r;
        r = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (trk_valid[k] && (trk_dest[k] == src) && (src != '0))
                r = {1'b1, stage_res[k*DW +: DW]};
        end
        return r;
    endfunction

    logic          stall_c;

`ifdef HAZARD_LOAD_USE_STALL_EN
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DEPTH-1:0] trk_load;
    logic             dec_load;
    logic             load_use;

    assign dec_load = (opcode == 4'd4);

    // Only stage 1 can hold a load whose data is not yet available.
    assign load_use = instr_valid && trk_valid[0] && trk_load[0] &&
                      ((use_rs && (rs == trk_dest[0])) ||
                       ((use_rt_op2 || use_rt_wd) && (rt == trk_dest[0])));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (load_use && !flush && !rst) begin
                    stall_c   = 1'b1;
                    state_nxt = STALL;
                end
            end
            STALL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            trk_load <= '0;
        end else begin
            trk_load[0] <= dec_load && !stall_c;
            for (int k = 1; k < DEPTH; k++)
                trk_load[k] <= trk_load[k-1];
        end
    end
`else
    assign stall_c = 1'b0;
`endif

    assign stall = stall_c;

    logic          take;
    logic          new_valid;
    logic [DW:0]   op1_lk, op2_lk, wd_lk;
    logic          op1_sel_d, op2_sel_d, wd_sel_d;

    assign take      = instr_valid && !flush && !stall_c;
    assign new_valid = take && has_dest && (dest != '0);

    assign op1_lk    = lookup(rs);
    assign op2_lk    = lookup(rt);
    assign wd_lk     = op2_lk;

    assign op1_sel_d = take && use_rs     && op1_lk[DW];
    assign op2_sel_d = take && use_rt_op2 && op2_lk[DW];
    assign wd_sel_d  = take && use_rt_wd  && wd_lk[DW];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            trk_valid <= '0;
            for (int k = 0; k < DEPTH; k++)
                trk_dest[k] <= '0;
        end else begin
            trk_valid[0] <= new_valid;
            trk_dest[0]  <= dest;
            for (int k = 1; k < DEPTH; k++) begin
                trk_valid[k] <= trk_valid[k-1];
                trk_dest[k]  <= trk_dest[k-1];
            end
        end
    end

    // Data outputs are zeroed whenever the matching select is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_op1_sel   <= 1'b0;
            fwd_op2_sel   <= 1'b0;
            fwd_wdata_sel <= 1'b0;
            fwd_op1       <= '0;
            fwd_op2       <= '0;
            fwd_wdata     <= '0;
        end else begin
            fwd_op1_sel   <= op1_sel_d;
            fwd_op2_sel   <= op2_sel_d;
            fwd_wdata_sel <= wd_sel_d;
            fwd_op1       <= op1_sel_d ? op1_lk[DW-1:0] : '0;
            fwd_op2       <= op2_sel_d ? op2_lk[DW-1:0] : '0;
            fwd_wdata     <= wd_sel_d  ? wd_lk[DW-1:0]  : '0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against
// a history-list reference model.
module tb_hazard_ctrl;

  localparam int DW = 16;
  localparam int DEPTH = 2;
`ifdef HAZARD_LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk, rst;
  logic [15:0] instr;
  logic instr_valid, flush;
  logic [DEPTH*DW-1:0] stage_res;
  logic fwd_op1_sel, fwd_op2_sel, fwd_wdata_sel, stall;
  logic [DW-1:0] fwd_op1, fwd_op2, fwd_wdata;

  hazard_ctrl #(.DW(DW), .AW(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .flush(flush),
    .stage_res(stage_res), .fwd_op1_sel(fwd_op1_sel), .fwd_op2_sel(fwd_op2_sel),
    .fwd_op1(fwd_op1), .fwd_op2(fwd_op2), .fwd_wdata_sel(fwd_wdata_sel),
    .fwd_wdata(fwd_wdata), .stall(stall)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: list of recent producers, element 0 = youngest
  typedef struct { bit v; int d; bit ld; } prod_t;
  prod_t hist[$];

  typedef struct {
    bit s1; int r1; bit s2; int r2; bit sw; int rw; bit hd; int d; bit ld;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] ins);
    dec_t x;
    int op, rs, rt, rd;
    op = int'(ins[15:12]); rs = int'(ins[11:9]); rt = int'(ins[8:6]); rd = int'(ins[5:3]);
    x = '{default: 0};
    case (op)
      0: begin x.s1 = 1; x.r1 = rs; x.s2 = 1; x.r2 = rt; x.hd = 1; x.d = rd; end
      1, 3: begin x.s2 = 1; x.r2 = rt; x.hd = 1; x.d = rs; end
      4: begin x.s1 = 1; x.r1 = rs; x.hd = 1; x.d = rt; x.ld = 1; end
      5: begin x.s1 = 1; x.r1 = rs; x.sw = 1; x.rw = rt; end
      6: begin x.s1 = 1; x.r1 = rs; x.s2 = 1; x.r2 = rt; end
      default: ;
    endcase
    return x;
  endfunction

  function automatic int find(input int src);
    if (src == 0) return -1;
    for (int k = 0; k < hist.size(); k++)
      if (hist[k].v && hist[k].d == src) return k;
    return -1;
  endfunction

  function automatic logic [15:0] mk(input int op, input int rs, input int rt, input int rd);
    return {op[3:0], rs[2:0], rt[2:0], rd[2:0], 3'b000};
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back('{v: 0, d: 0, ld: 0});
  endtask

  // driver tasks
  task automatic reset_dut();
    rst = 1'b1; instr = 16'h0000; instr_valid = 1'b0; flush = 1'b0; stage_res = '0;
    for (int c = 0; c < 3; c++) begin
      #3;
      check("rst_stall", stall, 0);
      @(posedge clk); #1;
      check("rst_op1_sel", fwd_op1_sel, 0);
      check("rst_op2_sel", fwd_op2_sel, 0);
      check("rst_wd_sel", fwd_wdata_sel, 0);
      check("rst_data", {fwd_op1, fwd_op2}, 0);
      check("rst_wdata", fwd_wdata, 0);
    end
    rst = 1'b0;
    prev_stall = 1'b0;
    model_clear();
  endtask

  task automatic step(input logic [15:0] ins, input logic iv, input logic fl,
                      input logic [31:0] sres, output logic stall_seen);
    dec_t x;
    bit e_stall, take;
    int k1, k2, kw;
    logic [15:0] e1, e2, ew;
    prod_t np;
    instr = ins; instr_valid = iv; flush = fl; stage_res = sres;
    x = decode(ins);
    e_stall = STALL_EN && iv && !fl && hist[0].v && hist[0].ld &&
              ((x.s1 && x.r1 == hist[0].d) || (x.s2 && x.r2 == hist[0].d) ||
               (x.sw && x.rw == hist[0].d));
    take = iv && !fl && !e_stall;
    k1 = x.s1 ? find(x.r1) : -1;
    k2 = x.s2 ? find(x.r2) : -1;
    kw = x.sw ? find(x.rw) : -1;
    e1 = (take && k1 >= 0) ? sres[k1*16 +: 16] : 16'h0;
    e2 = (take && k2 >= 0) ? sres[k2*16 +: 16] : 16'h0;
    ew = (take && kw >= 0) ? sres[kw*16 +: 16] : 16'h0;
    exp_q.push_back(16'(take && k1 >= 0)); exp_q.push_back(e1);
    exp_q.push_back(16'(take && k2 >= 0)); exp_q.push_back(e2);
    exp_q.push_back(16'(take && kw >= 0)); exp_q.push_back(ew);
    #3;
    stall_seen = stall;
    check("stall", stall, e_stall);
    check("no_double_stall", prev_stall & stall, 0);
    prev_stall = stall;
    @(posedge clk); #1;
    check("op1_sel", fwd_op1_sel, exp_q.pop_front());
    check("op1", fwd_op1, exp_q.pop_front());
    check("op2_sel", fwd_op2_sel, exp_q.pop_front());
    check("op2", fwd_op2, exp_q.pop_front());
    check("wd_sel", fwd_wdata_sel, exp_q.pop_front());
    check("wdata", fwd_wdata, exp_q.pop_front());
    if (fl) begin
      model_clear();
    end else begin
      np.v = take && x.hd && x.d != 0;
      np.d = x.d;
      np.ld = x.ld;
      hist.push_front(np);
      hist.pop_back();
    end
  endtask

  logic s;
  logic [15:0] cur;
  int op_sel;

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; flush = 1'b0; stage_res = '0;
    model_clear();
    @(posedge clk); #1;
    reset_dut();

    // R-type chain
    step(mk(0, 1, 2, 3), 1, 0, 32'h0, s);
    step(mk(0, 3, 1, 4), 1, 0, {16'h0000, 16'h1234}, s);
    check("chain_op1_sel", fwd_op1_sel, 1);
    check("chain_op1", fwd_op1, 16'h1234);

    // youngest producer wins
    reset_dut();
    step(mk(0, 1, 1, 2), 1, 0, 32'h0, s);
    step(mk(0, 1, 1, 2), 1, 0, 32'h0, s);
    step(mk(0, 1, 2, 7), 1, 0, {16'h5555, 16'hAAAA}, s);
    check("prio_op2_sel", fwd_op2_sel, 1);
    check("prio_op2", fwd_op2, 16'hAAAA);

    // load-use
    reset_dut();
    step(mk(4, 1, 4, 0), 1, 0, 32'h0, s);
    step(mk(0, 4, 1, 2), 1, 0, {16'h1111, 16'h2222}, s);
    check("lu_stall", s, STALL_EN);
    step(mk(0, 4, 1, 2), 1, 0, {16'hBEEF, 16'h3333}, s);
    check("lu_stall_once", s, 0);
    check("lu_op1_sel", fwd_op1_sel, 1);
    check("lu_op1", fwd_op1, 16'hBEEF);

    // reset during a load-use stall
    reset_dut();
    step(mk(4, 1, 4, 0), 1, 0, 32'h0, s);
    step(mk(0, 4, 1, 2), 1, 0, 32'h0, s);
    reset_dut();
    step(mk(0, 4, 1, 2), 1, 0, {16'h5A5A, 16'h6B6B}, s);
    check("rst_abort_stall", s, 0);
    check("rst_abort_op1_sel", fwd_op1_sel, 0);

    // store data forwarding
    reset_dut();
    step(mk(1, 5, 0, 0), 1, 0, 32'h0, s);
    step(mk(5, 1, 5, 0), 1, 0, {16'h0000, 16'h00FF}, s);
    check("sw_wd_sel", fwd_wdata_sel, 1);
    check("sw_wdata", fwd_wdata, 16'h00FF);
    check("sw_op2_sel", fwd_op2_sel, 0);

    // r0 never forwarded
    reset_dut();
    step(mk(0, 1, 1, 0), 1, 0, 32'h0, s);
    step(mk(0, 0, 1, 2), 1, 0, {16'h7777, 16'h8888}, s);
    check("r0_op1_sel", fwd_op1_sel, 0);

    // flush between producer and consumer
    reset_dut();
    step(mk(0, 1, 1, 6), 1, 0, 32'h0, s);
    step(mk(7, 0, 0, 0), 1, 1, 32'h0, s);
    step(mk(0, 6, 1, 2), 1, 0, {16'h9999, 16'hCCCC}, s);
    check("flush_op1_sel", fwd_op1_sel, 0);

    // randomized traffic; a stalled instruction is re-presented
    reset_dut();
    s = 1'b0;
    cur = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_dut();
        s = 1'b0;
      end
      if (!s) begin
        op_sel = $urandom_range(0, 8);
        case (op_sel)
          0, 7: cur = mk(0, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
          1: cur = mk(1, $urandom_range(0, 4), $urandom_range(0, 4), 0);
          2: cur = mk(3, $urandom_range(0, 4), $urandom_range(0, 4), 0);
          3, 8: cur = mk(4, $urandom_range(0, 4), $urandom_range(0, 4), 0);
          4: cur = mk(5, $urandom_range(0, 4), $urandom_range(0, 4), 0);
          5: cur = mk(6, $urandom_range(0, 4), $urandom_range(0, 4), 0);
          default: cur = mk($urandom_range(7, 15), $urandom_range(0, 7), $urandom_range(0, 7), 0);
        endcase
      end
      step(cur, ($urandom_range(0, 9) != 0) || s, $urandom_range(0, 19) == 0,
           {16'($urandom), 16'($urandom)}, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
